// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronizes phases A/B, decodes Gray-code steps
// into a modulo-2^N position count, and flags illegal two-bit jumps.
module quadrature_decoder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         a,
    input  logic         b,
    input  logic         en,
    input  logic         clr,
    input  logic         err_clr,
    output logic [N-1:0] Q,
    output logic         dir,
    output logic         step,
    output logic         err
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t     state;
    logic [1:0] sync1;      // {a,b} first stage
    logic [1:0] sync2;      // {A,B} phase pair used downstream
    logic [1:0] prev;       // P: last sampled phase pair
    logic [2:0] fill;       // marks when sync2 and prev hold post-reset samples

    logic [1:0] delta;
    logic       decode;
    logic       move_up;
    logic       move_dn;
    logic       illegal;

    // Position of a phase pair along the up sequence 00,10,11,01.
    function automatic logic [1:0] phase_index(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Decoding waits until prev holds a real sample; otherwise the reset
    // value 00 in the pipeline could pair with a held 11 and look illegal.
    always_comb begin
        decode  = (state == RUN) && fill[2];
        delta   = phase_index(sync2) - phase_index(prev);
        move_up = decode && (delta == 2'd1);
        move_dn = decode && (delta == 2'd3);
        illegal = decode && (delta == 2'd2);
    end

    // NOTE: every register here, synchronizer flops included, is reset so an
    // in-flight edge captured before reset can never be decoded afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            prev  <= 2'b00;
            fill  <= 3'b000;
            Q     <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments give every flop its pre-edge
            // value on the right-hand side, so ordering below is not a hazard.
            sync1 <= {a, b};
            sync2 <= sync1;
            fill  <= {fill[1:0], 1'b1};
            prev  <= sync2;
            step  <= 1'b0;

            case (state)
                INIT: state <= RUN;
                RUN: begin
                    if (move_up || move_dn) begin
                        dir <= move_up;
                        if (en) begin
                            step <= 1'b1;
                            Q    <= move_up ? Q + ONE : Q - ONE;
                        end
                    end
                end
                default: state <= INIT;
            endcase

            if (clr) begin
                Q <= '0;
            end

            if (illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed vector table, corner
// sequences and randomized phases compared against a history-based model.
module tb_quadrature_decoder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         a = 1'b0;
    logic         b = 1'b0;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic         err_clr = 1'b0;
    logic [N-1:0] Q;
    logic         dir;
    logic         step;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;
    int step_count = 0;

    quadrature_decoder #(.N(N)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .a      (a),
        .b      (b),
        .en     (en),
        .clr    (clr),
        .err_clr(err_clr),
        .Q      (Q),
        .dir    (dir),
        .step   (step),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Reference model: positions along the up sequence 00,10,11,01.
    int           pos_of [4] = '{0, 3, 1, 2};
    logic [1:0]   hist[$];
    int           edges;
    logic [N-1:0] m_q;
    logic         m_dir, m_step, m_err;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        edges  = 0;
        m_q    = '0;
        m_dir  = 1'b0;
        m_step = 1'b0;
        m_err  = 1'b0;
    endtask

    // An input sampled at edge k is compared with the one sampled at k-1
    // on edge k+2 (two synchronizer stages, then the decode).
    task automatic model_edge(input logic [1:0] ab, input logic en_i, input logic clr_i, input logic errc_i);
        int d;
        logic bad;
        edges++;
        hist.push_back(ab);
        if (hist.size() > 4) void'(hist.pop_front());
        m_step = 1'b0;
        bad    = 1'b0;
        if (edges >= 4) begin
            d = (pos_of[hist[1]] - pos_of[hist[0]] + 4) % 4;
            if (d == 1 || d == 3) begin
                m_dir = (d == 1);
                if (en_i) begin
                    m_step = 1'b1;
                    m_q    = (d == 1) ? m_q + 1'b1 : m_q - 1'b1;
                end
            end else if (d == 2) begin
                bad = 1'b1;
            end
        end
        if (clr_i) m_q = '0;
        if (bad) m_err = 1'b1;
        else if (errc_i) m_err = 1'b0;
    endtask

    task automatic tick(input logic [1:0] ab, input logic en_i, input logic clr_i, input logic errc_i);
        a       = ab[1];
        b       = ab[0];
        en      = en_i;
        clr     = clr_i;
        err_clr = errc_i;
        @(posedge clk);
        model_edge(ab, en_i, clr_i, errc_i);
        #1;
        if (step === 1'b1) step_count++;
        check("model_q", 32'(Q), 32'(m_q));
        check("model_dir", 32'(dir), 32'(m_dir));
        check("model_step", 32'(step), 32'(m_step));
        check("model_err", 32'(err), 32'(m_err));
    endtask

    // Asserts reset between clock edges, checks outputs clear at once, and
    // releases between edges with {a,b} held at ab.
    task automatic do_reset(input logic [1:0] ab);
        a = ab[1];
        b = ab[0];
        en = 1'b1;
        clr = 1'b0;
        err_clr = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_q", 32'(Q), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]   ab;
        logic         en;
        logic         clr;
        logic         err_clr;
        logic [N-1:0] q;
        logic         dir;
        logic         step;
        logic         err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [1:0] cur;
        logic [1:0] up_seq [4];
        logic       r_en, r_clr, r_ec;

        up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

        // Each vector is held for three edges; expectations apply after the
        // third (decode) edge. Starts from Q=0, dir=0, err=0, phase 00.
        vecs[0]  = '{2'b10, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{2'b00, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b11, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{2'b00, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{2'b00, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{2'b01, 1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{2'b00, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b1};

        model_reset();
        #1;

        // Four full up cycles from reset: Q=16, dir=1, 16 step pulses.
        do_reset(2'b00);
        repeat (5) tick(2'b00, 1'b1, 1'b0, 1'b0);
        step_count = 0;
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 4; p++)
                repeat (2) tick(up_seq[p], 1'b1, 1'b0, 1'b0);
        repeat (3) tick(2'b00, 1'b1, 1'b0, 1'b0);
        check("up4_q", 32'(Q), 32'd16);
        check("up4_dir", 32'(dir), 32'd1);
        check("up4_steps", 32'(step_count), 32'd16);

        // Wrap-around both ways.
        do_reset(2'b00);
        repeat (5) tick(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (3) tick(2'b01, 1'b1, 1'b0, 1'b0);
        check("wrap_dn_q", 32'(Q), 32'd255);
        check("wrap_dn_dir", 32'(dir), 32'd0);
        repeat (3) tick(2'b00, 1'b1, 1'b0, 1'b0);
        check("wrap_up_q", 32'(Q), 32'd0);
        check("wrap_up_dir", 32'(dir), 32'd1);

        // Vector table.
        do_reset(2'b00);
        repeat (5) tick(2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            repeat (3) tick(vecs[i].ab, vecs[i].en, vecs[i].clr, vecs[i].err_clr);
            check($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].q));
            check($sformatf("vec%0d_dir", i), 32'(dir), 32'(vecs[i].dir));
            check($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].step));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
        end

        // Release with a=b=1: no error, no count; then exact edge latency.
        do_reset(2'b11);
        for (int i = 0; i < 10; i++) begin
            tick(2'b11, 1'b1, 1'b0, 1'b0);
            check("hold11_q", 32'(Q), 32'd0);
            check("hold11_err", 32'(err), 32'd0);
        end
        tick(2'b01, 1'b1, 1'b0, 1'b0);
        check("lat_e1_q", 32'(Q), 32'd0);
        tick(2'b01, 1'b1, 1'b0, 1'b0);
        check("lat_e2_q", 32'(Q), 32'd0);
        tick(2'b01, 1'b1, 1'b0, 1'b0);
        check("lat_e3_q", 32'(Q), 32'd1);
        check("lat_e3_step", 32'(step), 32'd1);

        // Reset mid-sequence with an edge in flight; no step after release.
        tick(2'b00, 1'b1, 1'b0, 1'b0);
        tick(2'b10, 1'b1, 1'b0, 1'b0);
        do_reset(2'b10);
        step_count = 0;
        repeat (8) tick(2'b10, 1'b1, 1'b0, 1'b0);
        check("post_rst_steps", 32'(step_count), 32'd0);
        check("post_rst_q", 32'(Q), 32'd0);

        // Randomized phases, including illegal jumps and mid-run reset.
        cur = 2'b10;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 40) cur = 2'($urandom_range(3));
            r_en  = ($urandom_range(7) != 0);
            r_clr = ($urandom_range(31) == 0);
            r_ec  = ($urandom_range(15) == 0);
            if (i == 1500) do_reset(cur);
            tick(cur, r_en, r_clr, r_ec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter: N, default 8, width of position counter Q.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  1  encoder phase A, asynchronous to clk.
REQ-005 b  input  1  encoder phase B, asynchronous to clk.
REQ-006 en  input  1  synchronous count enable.
REQ-007 clr  input  1  synchronous clear of Q.
REQ-008 err_clr  input  1  synchronous clear of err.
REQ-009 Q  output  N  signed-agnostic position count, modulo 2^N.
REQ-010 dir  output  1  direction of last valid step: 1 = up, 0 = down.
REQ-011 step  output  1  one-cycle pulse per counted step.
REQ-012 err  output  1  sticky illegal-transition flag.

Function
REQ-013 a and b SHALL each pass through a two-flop synchronizer; only the second-stage values, the phase pair {A,B}, SHALL be used downstream.
REQ-014 A registered previous phase pair P SHALL hold the last sampled {A,B}, updated every cycle in state RUN.
REQ-015 The FSM SHALL have states INIT and RUN; reset SHALL enter INIT.
REQ-016 INIT SHALL last exactly one cycle: load P from {A,B}, no count, no step, no err; then go to RUN.
REQ-017 In RUN, up transitions (A leads B): 00->10, 10->11, 11->01, 01->00.
REQ-018 In RUN, down transitions: 00->01, 01->11, 11->10, 10->00.
REQ-019 {A,B} == P SHALL be idle: Q, dir unchanged, step = 0.
REQ-020 Two-bit changes (00<->11, 01<->10) SHALL be illegal: Q and dir unchanged, step = 0, err set to 1 next edge.
REQ-021 On a valid transition with en = 1: Q <= Q+1 (up) or Q-1 (down), dir updated, step = 1 for exactly one cycle.
REQ-022 On a valid transition with en = 0: Q unchanged, step = 0, dir still updated, P still tracks.
REQ-023 Latency: an edge on a or b SHALL be reflected in Q/step on the third rising clk edge after it is first sampled (2 sync + 1 decode).
REQ-024 Wrap-around: up from 2^N-1 SHALL give 0; down from 0 SHALL give 2^N-1; no saturation, no flag.
REQ-025 clr = 1 SHALL set Q to 0 next edge with priority over any simultaneous step; step and dir still reflect the transition.
REQ-026 err_clr = 1 SHALL clear err, except a simultaneous illegal transition SHALL leave err = 1.
REQ-027 step, dir, err, Q SHALL be registered outputs (no combinational path from a/b).

Reset
REQ-028 reset_n = 0 SHALL immediately force Q = 0, dir = 0, step = 0, err = 0, synchronizers and P = 00, state INIT.
REQ-029 Reset asserted mid-sequence SHALL discard in-flight synchronizer contents; after release, one INIT cycle precedes any count.
REQ-030 Release of reset with {a,b} = 11 SHALL not produce err or a count.

Verification
REQ-031 Reset, a/b held 00, en = 1, drive 4 full up cycles (00,10,11,01,00) -> Q = 16, dir = 1, 16 single-cycle step pulses.
REQ-032 N = 8, Q = 0, one down step -> Q = 255, dir = 0; then one up step -> Q = 0.
REQ-033 Jump 00 -> 11 in RUN -> err = 1, Q unchanged, step = 0; err_clr pulse -> err = 0; illegal jump coincident with err_clr -> err stays 1.
REQ-034 Q = 5, clr = 1 same cycle as up step -> Q = 0, step = 1, dir = 1; en = 0 with up steps -> Q held, step = 0.
REQ-035 Release reset with a = b = 1, hold 10 cycles -> Q = 0, err = 0; single input edge -> Q changes exactly 3 clk edges after first sampling.
REQ-036 Assert reset_n mid-sequence asynchronously (between clk edges) -> outputs zero immediately, no spurious step after release.
